bsg_manycore_link_relay_pipe: RTL



---
 rtl/bsg_manycore_link_relay_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_link_relay_pipe.sv
// bsg_manycore_link_relay_pipe
//
// Registered relay stage for one mesh link segment between two tiles.
// Each direction gets its own two-entry buffer. Outputs are driven only from
// registers, and ready_and_o depends only on the occupancy count, so no
// combinational path crosses the stage. Packets are carried through opaquely.
//
// Ports (side A is upstream of the forward channel, side B is the tile port):
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   fwd_v_i/fwd_data_i          forward packet in, from side A
//   fwd_ready_and_o             forward accept, to side A
//   fwd_v_o/fwd_data_o          forward packet out, to side B
//   fwd_ready_and_i             forward accept, from side B
//   rev_v_i/rev_data_i          reverse packet in, from side B
//   rev_ready_and_o             reverse accept, to side B
//   rev_v_o/rev_data_o          reverse packet out, to side A
//   rev_ready_and_i             reverse accept, from side A
//   drained_o                   both buffers empty

// Two-entry fully registered buffer (slot 0 = head, slot 1 = tail).
//
// count | meaning
//   0   | empty, output invalid
//   1   | head valid, can accept and pass through in the same cycle
//   2   | full, not accepting
module bsg_manycore_link_relay_buf #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_and_i,
  output logic               empty_o
);

  localparam logic [1:0] count_empty_lp = 2'd0;
  localparam logic [1:0] count_one_lp   = 2'd1;
  localparam logic [1:0] count_full_lp  = 2'd2;

  logic [1:0]         count_r;
  logic [width_p-1:0] slot0_r;
  logic [width_p-1:0] slot1_r;
  logic               enq;
  logic               deq;

  assign ready_and_o = (count_r != count_full_lp);
  assign v_o         = (count_r != count_empty_lp);
  assign data_o      = slot0_r;
  assign empty_o     = (count_r == count_empty_lp);

  // An offer while full is not a transfer; it is simply ignored.
  assign enq = v_i & ready_and_o;
  assign deq = v_o & ready_and_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= count_empty_lp;
    end else if (enq && !deq) begin
      count_r <= count_r + 2'd1;
    end else if (deq && !enq) begin
      count_r <= count_r - 2'd1;
    end
  end

  // Data slots carry no reset; they are only observed while v_o is high.
  always_ff @(posedge clk_i) begin
    if (enq && !deq) begin
      if (count_r == count_empty_lp) begin
        slot0_r <= data_i;
      end else begin
        slot1_r <= data_i;
      end
    end else if (deq && !enq) begin
      slot0_r <= slot1_r;
    end else if (enq && deq) begin
      // Only reachable at count 1: head leaves, the new packet becomes head.
      if (count_r == count_one_lp) begin
        slot0_r <= data_i;
      end
    end
  end

endmodule

module bsg_manycore_link_relay_pipe #(
  parameter int fwd_width_p = 8,
  parameter int rev_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,

  input  logic                   fwd_v_i,
  input  logic [fwd_width_p-1:0] fwd_data_i,
  output logic                   fwd_ready_and_o,
  output logic                   fwd_v_o,
  output logic [fwd_width_p-1:0] fwd_data_o,
  input  logic                   fwd_ready_and_i,

  input  logic                   rev_v_i,
  input  logic [rev_width_p-1:0] rev_data_i,
  output logic                   rev_ready_and_o,
  output logic                   rev_v_o,
  output logic [rev_width_p-1:0] rev_data_o,
  input  logic                   rev_ready_and_i,

  output logic                   drained_o
);

  logic fwd_empty;
  logic rev_empty;

  bsg_manycore_link_relay_buf #(.width_p(fwd_width_p)) fwd_buf (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (fwd_v_i),
    .data_i      (fwd_data_i),
    .ready_and_o (fwd_ready_and_o),
    .v_o         (fwd_v_o),
    .data_o      (fwd_data_o),
    .ready_and_i (fwd_ready_and_i),
    .empty_o     (fwd_empty)
  );

  bsg_manycore_link_relay_buf #(.width_p(rev_width_p)) rev_buf (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .v_i         (rev_v_i),
    .data_i      (rev_data_i),
    .ready_and_o (rev_ready_and_o),
    .v_o         (rev_v_o),
    .data_o      (rev_data_o),
    .ready_and_i (rev_ready_and_i),
    .empty_o     (rev_empty)
  );

  assign drained_o = fwd_empty & rev_empty;

endmodule
